// File: rtl/i2c_control_unit.sv
// I2C master bit-slot sequencer: generates SCL and steers the SDA data unit
// through start, address, data, ack and stop slots. All outputs are registered.
module i2c_control_unit #(
   parameter int LENGTH      = 8,
   parameter int HALF_PERIOD = 250
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              Go,
   input  logic              RWbit,
   input  logic [6:0]        Address,
   input  logic [LENGTH-1:0] WriteByte,
   input  logic [1:0]        NumBytes,
   input  logic              SDAsense,
   output logic              SCL,
   output logic [LENGTH-1:0] SentData,
   output logic              WriteLoad,
   output logic              ShiftorHold,
   output logic              ReadorWrite,
   output logic              Select,
   output logic              StartStopAck,
   output logic              Busy,
   output logic              ByteValid,
   output logic              Done,
   output logic              AckError
);
   localparam int PW = $clog2(2*HALF_PERIOD);
   localparam int BW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [PW-1:0] P_ONE  = PW'(1);
   localparam logic [PW-1:0] P_HALF = PW'(HALF_PERIOD);
   localparam logic [PW-1:0] P_SAMP = PW'(HALF_PERIOD + HALF_PERIOD/2);
   localparam logic [PW-1:0] P_END  = PW'(2*HALF_PERIOD - 1);
   localparam logic [BW-1:0] B_ONE  = BW'(1);
   localparam logic [BW-1:0] B_LAST = BW'(LENGTH - 1);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, STOP
   } state_t;

   typedef struct packed {
      logic scl;
      logic rel;
      logic sel;
      logic ssa;
      logic busy;
      logic shift;
      logic load;
      logic bvalid;
      logic done;
   } outs_t;

   state_t            state, n_state;
   logic [PW-1:0]     phase, n_phase;
   logic [BW-1:0]     bitcnt, n_bitcnt;
   logic              rw, n_rw;
   logic              more, n_more;
   logic              ackerr, n_ackerr;
   logic [LENGTH-1:0] wbyte, n_wbyte;
   logic [LENGTH-1:0] sent, n_sent;
   logic              slot_end;
   logic              hi, end_n;
   outs_t             o, n_o;

   always_comb begin
      n_state  = state;
      n_phase  = phase;
      n_bitcnt = bitcnt;
      n_rw     = rw;
      n_more   = more;
      n_ackerr = ackerr;
      n_wbyte  = wbyte;
      n_sent   = sent;
      slot_end = (phase == P_END);
      if (state != IDLE)
         n_phase = slot_end ? '0 : phase + P_ONE;
      case (state)
         IDLE: if (Go) begin
            n_state  = START;
            n_phase  = '0;
            n_bitcnt = '0;
            n_rw     = RWbit;
            n_more   = RWbit && (NumBytes == 2'd2);
            n_ackerr = 1'b0;
            n_wbyte  = WriteByte;
            n_sent   = LENGTH'({Address, RWbit});
         end
         START: if (slot_end) n_state = ADDR;
         ADDR, WDATA, RDATA: if (slot_end) begin
            n_bitcnt = bitcnt + B_ONE;
            if (bitcnt == B_LAST) begin
               n_bitcnt = '0;
               if (state == ADDR) begin
                  n_state = ADDR_ACK;
                  n_sent  = wbyte;   // staged so it is valid at the WDATA load
               end else if (state == WDATA) begin
                  n_state = WDATA_ACK;
               end else begin
                  n_state = RDATA_ACK;
               end
            end
         end
         ADDR_ACK, WDATA_ACK: begin
            if (phase == P_SAMP && SDAsense) n_ackerr = 1'b1;
            if (slot_end) begin
               if (ackerr || state == WDATA_ACK) n_state = STOP;
               else if (rw)                      n_state = RDATA;
               else                              n_state = WDATA;
            end
         end
         RDATA_ACK: if (slot_end) begin
            if (more) begin
               n_more  = 1'b0;
               n_state = RDATA;
            end else begin
               n_state = STOP;
            end
         end
         STOP: if (slot_end) n_state = IDLE;
         default: n_state = IDLE;
      endcase
   end

   // Outputs decoded from the next-cycle state so they can be registered.
   always_comb begin
      hi       = (n_phase >= P_HALF);
      end_n    = (n_phase == P_END);
      n_o      = '0;
      n_o.scl  = 1'b1;
      n_o.ssa  = 1'b1;
      n_o.busy = (n_state != IDLE);
      case (n_state)
         START: begin
            n_o.ssa  = ~hi;
            n_o.load = end_n;
         end
         ADDR, WDATA: begin
            n_o.scl   = hi;
            n_o.sel   = 1'b1;
            n_o.shift = end_n && (n_bitcnt != B_LAST);
         end
         ADDR_ACK: begin
            n_o.scl  = hi;
            n_o.rel  = 1'b1;
            n_o.load = end_n && !n_ackerr && !n_rw;
         end
         WDATA_ACK: begin
            n_o.scl = hi;
            n_o.rel = 1'b1;
         end
         RDATA: begin
            n_o.scl    = hi;
            n_o.rel    = 1'b1;
            n_o.shift  = (n_phase == P_SAMP);
            n_o.bvalid = end_n && (n_bitcnt == B_LAST);
         end
         RDATA_ACK: begin
            n_o.scl = hi;
            n_o.ssa = ~n_more;
         end
         STOP: begin
            n_o.scl  = hi;
            n_o.ssa  = (n_phase >= P_SAMP);
            n_o.done = end_n;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         state  <= IDLE;
         phase  <= '0;
         bitcnt <= '0;
         rw     <= 1'b0;
         more   <= 1'b0;
         ackerr <= 1'b0;
         wbyte  <= '0;
         sent   <= '0;
         o      <= '0;
         o.scl  <= 1'b1;
         o.ssa  <= 1'b1;
      end else begin
         state  <= n_state;
         phase  <= n_phase;
         bitcnt <= n_bitcnt;
         rw     <= n_rw;
         more   <= n_more;
         ackerr <= n_ackerr;
         wbyte  <= n_wbyte;
         sent   <= n_sent;
         o      <= n_o;
      end
   end

   assign SCL          = o.scl;
   assign ReadorWrite  = o.rel;
   assign Select       = o.sel;
   assign StartStopAck = o.ssa;
   assign Busy         = o.busy;
   assign ShiftorHold  = o.shift;
   assign WriteLoad    = o.load;
   assign ByteValid    = o.bvalid;
   assign Done         = o.done;
   assign SentData     = sent;
   assign AckError     = ackerr;
endmodule

// File: tb/tb_i2c_control_unit.sv
// Scoreboard bench for i2c_control_unit: transaction-level expectations are
// queued at issue time and matched by a monitor on each Done strobe.
module tb_i2c_control_unit;
   localparam int H    = 4;
   localparam int SLOT = 2*H;

   logic       clock = 1'b0;
   logic       Reset, Go, RWbit, SDAsense;
   logic [6:0] Address;
   logic [7:0] WriteByte, SentData;
   logic [1:0] NumBytes;
   logic       SCL, WriteLoad, ShiftorHold, ReadorWrite, Select, StartStopAck;
   logic       Busy, ByteValid, Done, AckError;

   i2c_control_unit #(.LENGTH(8), .HALF_PERIOD(H)) dut (
      .clock(clock), .Reset(Reset), .Go(Go), .RWbit(RWbit), .Address(Address),
      .WriteByte(WriteByte), .NumBytes(NumBytes), .SDAsense(SDAsense),
      .SCL(SCL), .SentData(SentData), .WriteLoad(WriteLoad),
      .ShiftorHold(ShiftorHold), .ReadorWrite(ReadorWrite), .Select(Select),
      .StartStopAck(StartStopAck), .Busy(Busy), .ByteValid(ByteValid),
      .Done(Done), .AckError(AckError)
   );

   always #5 clock = ~clock;

   typedef struct {
      int         cycles;
      int         shifts;
      int         nloads;
      logic [7:0] load0;
      logic [7:0] load1;
      int         nbv;
      logic [1:0] acks;
      logic       ackerr;
   } txn_t;

   txn_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: whole-transaction outcome from slot counts of the protocol.
   function automatic txn_t model(input logic [6:0] a, input logic rw, input logic [7:0] wb,
                                  input logic [1:0] nb, input logic an, input logic dn);
      txn_t t;
      int   nbytes, slots;
      nbytes   = (nb == 2'd2) ? 2 : 1;
      t.load0  = {a, rw};
      t.load1  = 8'h00;
      t.nloads = 1;
      t.nbv    = 0;
      t.acks   = 2'b00;
      t.ackerr = 1'b0;
      if (an) begin
         slots    = 11;
         t.shifts = 7;
         t.ackerr = 1'b1;
      end else if (!rw) begin
         slots    = 20;
         t.shifts = 14;
         t.nloads = 2;
         t.load1  = wb;
         t.ackerr = dn;
      end else begin
         slots    = 11 + 9*nbytes;
         t.shifts = 7 + 8*nbytes;
         t.nbv    = nbytes;
         t.acks   = (nbytes == 2) ? 2'b10 : 2'b01;
      end
      t.cycles = slots * SLOT;
      return t;
   endfunction

   // Monitor
   int         cyc, shifts, nloads, nbv;
   logic [7:0] load0, load1;
   logic [1:0] acks;
   bit         in_txn = 0, prev_bv = 0;
   txn_t       mt;

   always @(negedge clock) begin
      if (Reset) begin
         in_txn  = 0;
         prev_bv = 0;
      end else if (!Busy) begin
         chk("idle_lines", {SCL, StartStopAck, Select, ReadorWrite}, 4'b1100);
         chk("idle_strobes", {ShiftorHold, WriteLoad, ByteValid, Done}, 4'b0000);
      end else begin
         if (!in_txn) begin
            in_txn = 1; cyc = 0; shifts = 0; nloads = 0; nbv = 0;
            acks = 2'b00; prev_bv = 0; load0 = 8'h00; load1 = 8'h00;
            chk("start_lines", {SCL, StartStopAck, ReadorWrite}, 3'b110);
         end
         cyc++;
         if (ShiftorHold) shifts++;
         if (WriteLoad) begin
            if (nloads == 0) begin
               load0 = SentData;
               chk("start_end_lines", {SCL, StartStopAck}, 2'b10);
            end else begin
               load1 = SentData;
            end
            nloads++;
         end
         if (prev_bv) begin
            if (nbv == 1) acks[0] = StartStopAck;
            else if (nbv == 2) acks[1] = StartStopAck;
            chk("rack_lines", {SCL, ReadorWrite, Select}, 3'b000);
         end
         prev_bv = ByteValid;
         if (ByteValid) nbv++;
         if (Done) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got Done expected none at %0t", $time);
            end else begin
               mt = exp_q.pop_front();
               chk("cycles", cyc, mt.cycles);
               chk("shifts", shifts, mt.shifts);
               chk("nloads", nloads, mt.nloads);
               chk("load0", load0, mt.load0);
               if (mt.nloads == 2) chk("load1", load1, mt.load1);
               chk("bytevalids", nbv, mt.nbv);
               chk("rack_levels", acks, mt.acks);
               chk("ackerr", AckError, mt.ackerr);
               chk("stop_end_lines", {SCL, StartStopAck, Select, ReadorWrite}, 4'b1100);
            end
            in_txn = 0;
         end
      end
   end

   // Issue one transaction; the slave side acks according to an/dn.
   task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] wb,
                          input logic [1:0] nb, input logic an, input logic dn,
                          input bit stray, input int rst_at);
      txn_t t;
      int   go_at, slot;
      t = model(a, rw, wb, nb, an, dn);
      if (rst_at < 0) exp_q.push_back(t);
      Address = a; RWbit = rw; WriteByte = wb; NumBytes = nb; Go = 1'b1;
      @(posedge clock); #1;
      Go = 1'b0;
      Address = 7'($urandom); WriteByte = 8'($urandom);
      RWbit = 1'($urandom); NumBytes = 2'($urandom_range(2, 0));
      go_at = stray ? int'($urandom_range(t.cycles - 1, 1)) : -1;
      for (int c = 0; c < t.cycles; c++) begin
         slot = c / SLOT;
         if (slot == 9)               SDAsense = an;
         else if (slot == 18 && !rw)  SDAsense = dn;
         else                         SDAsense = 1'($urandom);
         Go = (c == go_at);
         if (c == rst_at) Reset = 1'b1;
         @(posedge clock); #1;
         Go = 1'b0;
         if (c == rst_at) begin
            Reset = 1'b0;
            @(negedge clock);
            chk("rst_lines", {Busy, SCL, StartStopAck, Select, ReadorWrite}, 5'b01100);
            chk("rst_strobes", {ShiftorHold, WriteLoad, ByteValid, Done}, 4'b0000);
            chk("rst_sentdata", SentData, 8'h00);
            chk("rst_ackerr", AckError, 1'b0);
            break;
         end
      end
      repeat (3) @(posedge clock);
      #1;
   endtask

   initial begin
      Reset = 1'b1; Go = 1'b0; RWbit = 1'b0; Address = '0; WriteByte = '0;
      NumBytes = '0; SDAsense = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_lines", {Busy, SCL, StartStopAck, Select, ReadorWrite}, 5'b01100);
      chk("reset_strobes", {ShiftorHold, WriteLoad, ByteValid, Done}, 4'b0000);
      chk("reset_sentdata", SentData, 8'h00);
      chk("reset_ackerr", AckError, 1'b0);
      @(posedge clock); #1;
      Reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      run_txn(7'h48, 1'b0, 8'h01, 2'd0, 1'b0, 1'b0, 1'b0, -1);
      run_txn(7'h48, 1'b1, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0, -1);
      run_txn(7'h48, 1'b0, 8'h5A, 2'd1, 1'b1, 1'b0, 1'b0, -1);
      run_txn(7'h48, 1'b1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, -1);
      run_txn(7'h2C, 1'b1, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0, 13*SLOT + 5);
      run_txn(7'h11, 1'b0, 8'hC3, 2'd2, 1'b0, 1'b0, 1'b1, -1);
      run_txn(7'h11, 1'b0, 8'hC3, 2'd0, 1'b0, 1'b1, 1'b0, -1);
      run_txn(7'h7F, 1'b1, 8'h00, 2'd1, 1'b1, 1'b0, 1'b1, -1);
      for (int i = 0; i < 20; i++)
         run_txn(7'($urandom), 1'($urandom), 8'($urandom), 2'($urandom_range(2, 0)),
                 $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
                 1'($urandom), -1);

      repeat (10) @(posedge clock);
      #1;
      chk("pending_txns", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
